text_dump_tx: RTL and testbench
===============================

Name: text_dump_tx

Overview:
- Read-side companion to the text-RAM writer.
- On command, walks the character buffer row by row and serialises each byte as 8N1 UART on one pin, giving a host readback of screen contents.
- Sits beside the VGA engine on the PLL global clock and uses its own read port of the text RAM.

Parameters:
- CLKS_PER_BIT, 218, clocks per UART bit (25.175 MHz / 115200); must be >= 2.
- TEXT_COLS, 80, characters per row.
- TEXT_ROWS, 30, rows per screen.
- ADDR_W, 12, text-RAM address width; TEXT_COLS*TEXT_ROWS must be <= 2**ADDR_W.

Ports:
- i_clk  in  1  system clock (PLL output via global buffer).
- i_rst  in  1  reset; synchronous, active-high.
- i_start  in  1  one-cycle pulse: begin a full-screen dump.
- i_abort  in  1  level: stop after the current frame completes.
- o_rd_en  out  1  text-RAM read strobe.
- o_rd_addr  out  ADDR_W  text-RAM read address.
- i_rd_data  in  8  text-RAM read data; valid exactly 1 cycle after o_rd_en.
- o_tx  out  1  UART line; idle high.
- o_busy  out  1  high from the accepted start until the last stop bit ends.
- o_done  out  1  one-cycle pulse at the end of a dump (normal or aborted).

Behaviour:
- Reset values: o_tx=1, o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0. Internal state is IDLE, counters 0. Reset asserted mid-frame forces o_tx high on the next edge; no partial frame resumes.
- FSM states: IDLE, FETCH, WAIT, START, DATA, STOP, NEXT.
- IDLE:
  - i_start=1 -> FETCH; o_busy=1; char address := 0.
  - i_start while busy is ignored.
- FETCH: o_rd_en=1 for one cycle with o_rd_addr=char address -> WAIT.
- WAIT: latch i_rd_data into the shift register -> START.
- START: o_tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA:
  - 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit index 0..7 (3 bits); after bit 7 -> STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles -> NEXT.
- NEXT:
  - If char address = TEXT_COLS*TEXT_ROWS-1 or abort is latched: o_done=1 for one cycle, o_busy=0 -> IDLE.
  - Otherwise: char address += 1 -> FETCH.
- Baud counter:
  - Width clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then clears on the bit boundary.
- Timing:
  - Start pulse to start-bit falling edge: 3 cycles (IDLE->FETCH->WAIT->START registered).
  - Frame period: 10*CLKS_PER_BIT + 3 cycles per character (NEXT, FETCH, WAIT).
- Abort:
  - i_abort sampled every cycle while busy and latched sticky; the latch clears on entry to IDLE.
  - The in-flight frame always completes; no truncated characters.
- Simultaneous i_start and i_abort in IDLE: start is accepted and abort is latched, so exactly one character (address 0) is sent, then done.
- Address never exceeds TEXT_COLS*TEXT_ROWS-1, so it does not wrap into unused RAM.
- o_tx is driven from a register, so there are no glitches.

Optional Feature:
- Macro: TEXT_DUMP_CRLF_EN.
- Defined:
  - After the character at column TEXT_COLS-1 of each row, the block sends 0x0D then 0x0A as extra frames, without RAM reads (NEXT -> START with the constant loaded).
  - Abort is honoured only after the LF, so rows stay line-terminated.
  - Total frames per dump: TEXT_ROWS*(TEXT_COLS+2).
- Undefined: the raw TEXT_COLS*TEXT_ROWS bytes are sent, with no line breaks.

Decomposition:
- Shared package/header:
  - Default geometry constants (TEXT_COLS=80, TEXT_ROWS=30, ADDR_W=12).
  - CHAR_CR=8'h0D, CHAR_LF=8'h0A.
  - FSM state encodings.
  - Values are shared with the writer and VGA engine.
- Natural sub-module: uart_tx_byte (start/data/stop serialiser with a baud counter; handshake in_valid/in_ready/o_tx). text_dump_tx keeps only the address walk and the CRLF insertion.

Test Plan (sim: CLKS_PER_BIT=4, TEXT_COLS=4, TEXT_ROWS=2; RAM model preloaded with 0x41..0x48):
- Full dump:
  - Pulse i_start -> o_tx falls 3 cycles later.
  - 8 frames decode to 0x41..0x48 LSB-first, each 43 cycles apart.
  - o_done pulses once; o_busy low after it.
- Read timing: o_rd_addr sequence is 0,1,...,7; each o_rd_en is exactly 1 cycle wide; data is sampled 1 cycle later; no address 8 is ever issued.
- Abort:
  - Assert i_abort during frame 3 (0x43) -> frame completes with a correct stop bit.
  - No fetch of address 3; o_done pulses; IDLE.
- Reset mid-frame: i_rst during DATA bit 4 -> o_tx=1 and o_busy=0 on the next edge; a later i_start restarts at address 0.
- Start while busy: second i_start pulse mid-dump -> ignored; still exactly 8 frames and one o_done.
- With TEXT_DUMP_CRLF_EN: frame stream is 41 42 43 44 0D 0A 45 46 47 48 0D 0A (12 frames); address sequence is unchanged.

Source files
------------

// File: rtl/text_dump_tx_pkg.sv
// rtl/text_dump_tx_pkg.sv - shared text-screen geometry, line-ending bytes and FSM encodings
package text_dump_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 218;
  localparam int DEF_TEXT_COLS    = 80;
  localparam int DEF_TEXT_ROWS    = 30;
  localparam int DEF_ADDR_W       = 12;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_NEXT
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    EOL_NONE,
    EOL_CR,
    EOL_LF
  } eol_t;

endpackage

// File: rtl/text_dump_tx_if.sv
// rtl/text_dump_tx_if.sv - control, text-RAM read port and UART line of the screen dumper
interface text_dump_tx_if #(
  parameter int ADDR_W = 12
);
  logic              i_start;
  logic              i_abort;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [7:0]        i_rd_data;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_abort, i_rd_data,
    input  o_rd_en, o_rd_addr, o_tx, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_rd_data,
    output o_rd_en, o_rd_addr, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/text_dump_tx_uart_tx_byte.sv
// rtl/text_dump_tx_uart_tx_byte.sv - 8N1 byte serialiser; in_ready rises in the last stop cycle so frames can abut
module uart_tx_byte
  import text_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       o_tx
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  assign bit_end  = (cnt == CNT_LAST);
  assign in_ready = (state == TX_IDLE) || (state == TX_STOP && bit_end);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= TX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (in_valid) state_nxt = TX_START;
      TX_START: if (bit_end) state_nxt = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = TX_STOP;
      TX_STOP:  if (bit_end) state_nxt = in_valid ? TX_START : TX_IDLE;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      o_tx    <= 1'b1;
    end else begin
      cnt <= (state == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
      if (in_valid && in_ready) begin
        shift   <= in_data;
        bit_idx <= '0;
        o_tx    <= 1'b0;
      end else if (bit_end) begin
        case (state)
          TX_START: begin
            o_tx  <= shift[0];
            shift <= {1'b0, shift[7:1]};
          end
          TX_DATA: begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              o_tx <= 1'b1;
            end else begin
              o_tx  <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end
          default: o_tx <= 1'b1;
        endcase
      end
    end
  end
endmodule

// File: rtl/text_dump_tx.sv
// rtl/text_dump_tx.sv - walks the text RAM and streams it out as UART; TEXT_DUMP_CRLF_EN adds CR LF per row
module text_dump_tx
  import text_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TEXT_COLS    = DEF_TEXT_COLS,
  parameter int TEXT_ROWS    = DEF_TEXT_ROWS,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  text_dump_tx_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEXT_COLS * TEXT_ROWS - 1);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              abort_q;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              finish;

`ifdef TEXT_DUMP_CRLF_EN
  localparam int COL_W = (TEXT_COLS > 1) ? $clog2(TEXT_COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(TEXT_COLS - 1);
  logic [COL_W-1:0] col;
  eol_t             eol;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = bus.i_rd_data;
    finish    = 1'b0;
    case (state)
      ST_IDLE:  if (bus.i_start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        tx_valid  = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND:  if (tx_ready) state_nxt = ST_NEXT;
      ST_NEXT: begin
`ifdef TEXT_DUMP_CRLF_EN
        // Line ending goes out before abort/last checks so every row stays terminated
        if (eol == EOL_NONE && col == LAST_COL) begin
          tx_valid  = 1'b1;
          tx_data   = CHAR_CR;
          state_nxt = ST_SEND;
        end else if (eol == EOL_CR) begin
          tx_valid  = 1'b1;
          tx_data   = CHAR_LF;
          state_nxt = ST_SEND;
        end else
`endif
        if (addr == LAST_ADDR || abort_q) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr    <= '0;
      abort_q <= 1'b0;
`ifdef TEXT_DUMP_CRLF_EN
      col     <= '0;
      eol     <= EOL_NONE;
`endif
    end else begin
      if (state_nxt == ST_IDLE) abort_q <= 1'b0;
      else if (bus.i_abort)     abort_q <= 1'b1;

      if (state == ST_IDLE && bus.i_start) begin
        addr <= '0;
`ifdef TEXT_DUMP_CRLF_EN
        col  <= '0;
        eol  <= EOL_NONE;
`endif
      end else if (state == ST_NEXT && state_nxt == ST_FETCH) begin
        addr <= addr + 1'b1;
`ifdef TEXT_DUMP_CRLF_EN
        col  <= (col == LAST_COL) ? '0 : col + 1'b1;
        eol  <= EOL_NONE;
`endif
      end
`ifdef TEXT_DUMP_CRLF_EN
      if (state == ST_NEXT && tx_valid) eol <= (eol == EOL_NONE) ? EOL_CR : EOL_LF;
`endif
    end
  end

  assign bus.o_rd_en   = (state == ST_FETCH);
  assign bus.o_rd_addr = addr;
  assign bus.o_busy    = (state != ST_IDLE) && !finish;
  assign bus.o_done    = finish;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_valid (tx_valid),
    .in_ready (tx_ready),
    .in_data  (tx_data),
    .o_tx     (bus.o_tx)
  );
endmodule

// File: tb/tb_text_dump_tx.sv
// tb/tb_text_dump_tx.sv - randomized bench for text_dump_tx with a UART decoder and frame-stream model
module tb_text_dump_tx;
  localparam int CPB  = 4;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int N    = COLS * ROWS;
  localparam int AW   = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_dump_tx_if #(.ADDR_W(AW)) bus ();

  text_dump_tx #(
    .CLKS_PER_BIT(CPB),
    .TEXT_COLS   (COLS),
    .TEXT_ROWS   (ROWS),
    .ADDR_W      (AW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic [7:0] ram [N];
  always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= ram[bus.o_rd_addr[2:0]];

  int total = 0;
  int bad   = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART decoder: k counts negedges from the first low sample of a frame
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         rd_q[$];
  int         frames_started = 0;
  int         done_cnt = 0;
  bit         active = 1'b0;
  int         k = 0;
  logic [7:0] sh = '0;
  logic       prev_rd_en = 1'b0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      active <= 1'b0;
      k      <= 0;
    end else if (!active) begin
      if (bus.o_tx === 1'b0) begin
        active         <= 1'b1;
        k              <= 1;
        frames_started <= frames_started + 1;
        rx_start_q.push_back(cyc);
      end
    end else begin
      if (k == 2) chk("start_bit", bus.o_tx, 1'b0);
      if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) sh <= {bus.o_tx, sh[7:1]};
      if (k == 38) chk("stop_bit", bus.o_tx, 1'b1);
      if (k == 39) begin
        active <= 1'b0;
        rx_q.push_back(sh);
      end
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.o_rd_en === 1'b1) begin
      chk("rd_en_width", prev_rd_en, 1'b0);
      chk("rd_addr_range", bus.o_rd_addr < N, 1'b1);
      rd_q.push_back(int'(bus.o_rd_addr));
    end
    prev_rd_en <= bus.o_rd_en;
    if (!rst && bus.o_done === 1'b1) begin
      chk("done_width", prev_done, 1'b0);
      chk("busy_at_done", bus.o_busy, 1'b0);
      done_cnt <= done_cnt + 1;
    end
    prev_done <= bus.o_done;
  end

  // abort_frame: -1 none, -2 together with start, else frame index during which abort rises
  task automatic run_dump(input string name, input bit rand_ram, input int abort_frame, input int restart_frame);
    logic [7:0] exp_q[$];
    bit         uend_q[$];
    bit         ischar_q[$];
    int nexp, nchars, start_c, done_base, fs_base, rx_base, rs_base, rd_base, got, j;
    bit ab_on, rs_on;
    ab_on = 1'b0;
    rs_on = 1'b0;
    if (rand_ram) for (int i = 0; i < N; i++) ram[i] = 8'($urandom_range(0, 255));
    for (int a = 0; a < N; a++) begin
      exp_q.push_back(ram[a]);
      ischar_q.push_back(1'b1);
`ifdef TEXT_DUMP_CRLF_EN
      if (a % COLS == COLS - 1) begin
        uend_q.push_back(1'b0);
        exp_q.push_back(8'h0D); uend_q.push_back(1'b0); ischar_q.push_back(1'b0);
        exp_q.push_back(8'h0A); uend_q.push_back(1'b1); ischar_q.push_back(1'b0);
      end else begin
        uend_q.push_back(1'b1);
      end
`else
      uend_q.push_back(1'b1);
`endif
    end
    nexp = exp_q.size();
    if (abort_frame != -1) begin
      j = (abort_frame < 0) ? 0 : abort_frame;
      while (!uend_q[j]) j++;
      nexp = j + 1;
    end
    nchars = 0;
    for (int i = 0; i < nexp; i++) if (ischar_q[i]) nchars++;

    done_base = done_cnt;
    fs_base   = frames_started;
    rx_base   = rx_q.size();
    rs_base   = rx_start_q.size();
    rd_base   = rd_q.size();

    bus.i_start = 1'b1;
    if (abort_frame == -2) bus.i_abort = 1'b1;
    start_c = cyc;
    @(posedge clk) #1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk({name, "_busy_after_start"}, bus.o_busy, 1'b1);
    for (int t = 0; t < 3000 && done_cnt == done_base; t++) begin
      if (abort_frame >= 0 && !ab_on && frames_started - fs_base == abort_frame + 1) begin
        bus.i_abort = 1'b1;
        ab_on = 1'b1;
      end
      if (restart_frame >= 0 && !rs_on && frames_started - fs_base == restart_frame + 1) begin
        bus.i_start = 1'b1;
        rs_on = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(posedge clk) #1;
    end
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk({name, "_done_seen"}, done_cnt != done_base, 1'b1);
    repeat (4) @(posedge clk) #1;
    chk({name, "_done_count"}, done_cnt - done_base, 1);
    chk({name, "_busy_idle"}, bus.o_busy, 1'b0);
    chk({name, "_tx_idle"}, bus.o_tx, 1'b1);

    got = rx_q.size() - rx_base;
    chk({name, "_frames"}, got, nexp);
    for (int i = 0; i < nexp && i < got; i++) chk({name, "_byte"}, rx_q[rx_base + i], exp_q[i]);
    chk({name, "_reads"}, rd_q.size() - rd_base, nchars);
    for (int i = 0; i < nchars && rd_base + i < rd_q.size(); i++) chk({name, "_rd_addr"}, rd_q[rd_base + i], i);
    if (got > 0) chk({name, "_start_latency"}, rx_start_q[rs_base] - start_c, 3);
`ifndef TEXT_DUMP_CRLF_EN
    for (int i = 1; i < got; i++)
      chk({name, "_frame_period"}, rx_start_q[rs_base + i] - rx_start_q[rs_base + i - 1], 10 * CPB + 3);
`endif
  endtask

  task automatic reset_mid();
    int fs_base, done_base;
    bit found;
    found     = 1'b0;
    fs_base   = frames_started;
    done_base = done_cnt;
    bus.i_start = 1'b1;
    @(posedge clk) #1;
    bus.i_start = 1'b0;
    for (int t = 0; t < 500 && !found; t++) begin
      if (frames_started - fs_base >= 2 && k == 21) found = 1'b1;
      else @(posedge clk) #1;
    end
    chk("rst_reach_bit4", found, 1'b1);
    rst = 1'b1;
    @(posedge clk) #1;
    chk("rst_mid_tx", bus.o_tx, 1'b1);
    chk("rst_mid_busy", bus.o_busy, 1'b0);
    chk("rst_mid_rd_addr", bus.o_rd_addr, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk) #1;
    chk("rst_mid_no_done", done_cnt - done_base, 0);
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) ram[i] = 8'(8'h41 + i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.o_tx, 1'b1);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_done", bus.o_done, 1'b0);
    chk("rst_rd_en", bus.o_rd_en, 1'b0);
    chk("rst_rd_addr", bus.o_rd_addr, 0);
    rst = 1'b0;
    @(posedge clk) #1;

    run_dump("full", 1'b0, -1, -1);
    run_dump("abort", 1'b0, 2, -1);
    run_dump("start_abort", 1'b0, -2, -1);
    run_dump("busy_start", 1'b1, -1, int'($urandom_range(0, 6)));
    reset_mid();
    run_dump("after_rst", 1'b1, -1, -1);
    for (int r = 0; r < 4; r++)
      run_dump("rand", 1'b1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
